// File: rtl/lane_operand_buffer.sv
// Per-lane operand buffer: credit-guarded FIFO between the VRF crossbar and one operand consumer.
// Optional zero-latency bypass when the FIFO is empty: define LANE_OPBUF_BYPASS_EN.
module lane_operand_buffer #(
  parameter int Depth     = 4,
  parameter int DataWidth = 64,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 credit_take_i,
  output logic                 credit_avail_o,
  output logic                 credit_err_o,
  input  logic [DataWidth-1:0] operand_i,
  input  logic                 operand_valid_i,
  output logic [DataWidth-1:0] operand_o,
  output logic                 operand_valid_o,
  input  logic                 operand_ready_i,
  output logic                 operand_last_o
);
  localparam int CW = $clog2(Depth + 1);
  localparam int PW = $clog2(Depth);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [DataWidth-1:0] mem [Depth];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count, credits;
  logic [LenWidth-1:0]  remaining;
  state_e               state;
  logic                 drop_q;

  logic active, drop, empty, full, bypass;
  logic pop, pop_fifo, push_req, push, wr_ovf, take_ok, take_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign active = (state == ACTIVE);
  // Flush cycle plus the next one: covers a read granted just before the flush.
  assign drop   = flush_i | drop_q;
  assign empty  = (count == '0);
  assign full   = (count == CW'(Depth));

`ifdef LANE_OPBUF_BYPASS_EN
  assign bypass = active & empty & operand_valid_i & ~drop;
`else
  assign bypass = 1'b0;
`endif

  assign operand_valid_o = active & (~empty | bypass);
  assign operand_o       = !operand_valid_o ? '0 : (empty ? operand_i : mem[rptr]);
  assign operand_last_o  = operand_valid_o & (remaining == LenWidth'(1));
  assign cmd_ready_o     = ~active & ~flush_i;
  assign credit_avail_o  = (credits != '0);

  assign pop      = operand_valid_o & operand_ready_i & ~flush_i;
  assign pop_fifo = pop & ~empty;
  assign push_req = operand_valid_i & ~drop & ~(bypass & operand_ready_i);
  assign push     = push_req & (~full | pop_fifo);
  assign wr_ovf   = push_req & full & ~pop_fifo;
  assign take_ok  = credit_take_i & (credits != '0);
  assign take_err = credit_take_i & (credits == '0) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= operand_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)     wptr <= ptr_inc(wptr);
      if (pop_fifo) rptr <= ptr_inc(rptr);
      case ({push, pop_fifo})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits      <= CW'(Depth);
      credit_err_o <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= flush_i;
      if (take_err | wr_ovf) credit_err_o <= 1'b1;
      if (flush_i) credits <= CW'(Depth);
      else begin
        case ({pop, take_ok})
          2'b10:   if (credits != CW'(Depth)) credits <= credits + 1'b1;
          2'b01:   credits <= credits - 1'b1;
          default: credits <= credits;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (flush_i) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i && cmd_len_i != '0) begin
          remaining <= cmd_len_i;
          state     <= ACTIVE;
        end
        ACTIVE: if (pop) begin
          remaining <= remaining - 1'b1;
          if (remaining == LenWidth'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_operand_buffer.sv
// Scoreboard bench for lane_operand_buffer (default build, Depth=4).
module tb_lane_operand_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, cmd_valid, cmd_ready, take, avail, err;
  logic [15:0] cmd_len;
  logic [63:0] op_in, op_out;
  logic        op_vin, op_vout, op_rdy, op_last;

  typedef struct {logic [63:0] data; logic last;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lane_operand_buffer #(.Depth(4), .DataWidth(64), .LenWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
    .credit_take_i(take), .credit_avail_o(avail), .credit_err_o(err),
    .operand_i(op_in), .operand_valid_i(op_vin),
    .operand_o(op_out), .operand_valid_o(op_vout),
    .operand_ready_i(op_rdy), .operand_last_o(op_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumer handshake pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && op_vout && op_rdy) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_pop: got %0h, expected no output", op_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pop_data", op_out, e.data);
        check("pop_last", {63'd0, op_last}, {63'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    flush = 0; cmd_valid = 0; cmd_len = 0; take = 0;
    op_in = 0; op_vin = 0; op_rdy = 0;
  endtask

  task automatic exp_push(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d; e.last = l;
    q.push_back(e);
  endtask

  task automatic do_reset();
    clr();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    check("rst_valid", {63'd0, op_vout}, 64'd0);
    check("rst_last", {63'd0, op_last}, 64'd0);
    check("rst_data", op_out, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_avail", {63'd0, avail}, 64'd1);
    check("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1;

    // Basic stream, len=3
    cmd_valid = 1; cmd_len = 3; take = 1; tick();
    check("basic_empty", {63'd0, op_vout}, 64'd0);
    cmd_valid = 0; op_rdy = 1; op_vin = 1; op_in = 64'hA; exp_push(64'hA, 0); tick();
    check("basic_latency", {63'd0, op_vout}, 64'd1);
    op_in = 64'hB; exp_push(64'hB, 0); tick();
    take = 0; op_in = 64'hC; exp_push(64'hC, 1); tick();
    op_vin = 0; tick();
    check("basic_idle_ready", {63'd0, cmd_ready}, 64'd1);
    check("basic_idle_valid", {63'd0, op_vout}, 64'd0);
    check("basic_drained", q.size(), 0);

    // Credit exhaustion
    do_reset();
    take = 1; tick();
    op_vin = 1; op_in = 64'h1; tick();
    op_in = 64'h2; tick();
    check("cred_three", {63'd0, avail}, 64'd1);
    op_in = 64'h3; tick();
    check("cred_zero", {63'd0, avail}, 64'd0);
    check("cred_no_err", {63'd0, err}, 64'd0);
    op_in = 64'h4; tick();
    check("cred_err", {63'd0, err}, 64'd1);
    check("cred_sat", {63'd0, avail}, 64'd0);
    take = 0; op_vin = 0; cmd_valid = 1; cmd_len = 4;
    exp_push(64'h1, 0); exp_push(64'h2, 0); exp_push(64'h3, 0); exp_push(64'h4, 1);
    tick();
    cmd_valid = 0; op_rdy = 1; tick();
    check("cred_return", {63'd0, avail}, 64'd1);
    tick(); tick(); tick();
    op_rdy = 0; tick();
    check("cred_err_sticky", {63'd0, err}, 64'd1);
    check("cred_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("cred_drained", q.size(), 0);

    // Backpressure and wrap, len=10
    do_reset();
    cmd_valid = 1; cmd_len = 10; tick();
    cmd_valid = 0;
    begin
      int issued = 0, sent = 0;
      logic pend = 0;
      bit done = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        op_vin = pend;
        if (pend) begin
          op_in = 64'h100 + 64'(sent);
          exp_push(64'h100 + 64'(sent), sent == 9);
          sent++;
        end
        take = (issued < 10) && avail;
        if (take) issued++;
        pend = take;
        op_rdy = (cyc % 2) == 1;
        tick();
        done = (issued == 10) && !pend && (q.size() == 0);
      end
      check("bp_timeout", {63'd0, done}, 64'd1);
    end
    clr(); tick();
    check("bp_err", {63'd0, err}, 64'd0);
    check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Flush with in-flight read
    do_reset();
    cmd_valid = 1; cmd_len = 5; take = 1; tick();
    cmd_valid = 0; op_vin = 1; op_in = 64'hD1; tick();
    op_in = 64'hD2; flush = 1; cmd_valid = 1; cmd_len = 2; #1;
    check("flush_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    tick();
    flush = 0; cmd_valid = 0; take = 0; op_in = 64'hBAD; tick();
    op_vin = 0;
    check("flush_valid", {63'd0, op_vout}, 64'd0);
    check("flush_cmd_idle", {63'd0, cmd_ready}, 64'd1);
    check("flush_avail", {63'd0, avail}, 64'd1);
    cmd_valid = 1; cmd_len = 1; take = 1; tick();
    cmd_valid = 0; take = 0; op_vin = 1; op_in = 64'h5EED; op_rdy = 1; exp_push(64'h5EED, 1); tick();
    op_vin = 0; tick(); op_rdy = 0;
    take = 1; tick(); tick(); tick();
    check("flush_cred_3", {63'd0, avail}, 64'd1);
    tick();
    check("flush_cred_4", {63'd0, avail}, 64'd0);
    take = 0;
    check("flush_drained", q.size(), 0);

    // Zero-length descriptor and take+pop in the same cycle
    do_reset();
    take = 1; tick();
    op_vin = 1; op_in = 64'hE1; tick();
    take = 0; op_in = 64'hE2; cmd_valid = 1; cmd_len = 0; tick();
    op_vin = 0;
    check("zero_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("zero_valid", {63'd0, op_vout}, 64'd0);
    cmd_len = 2; exp_push(64'hE1, 0); exp_push(64'hE2, 1); tick();
    cmd_valid = 0; op_rdy = 1; take = 1; tick();
    op_rdy = 0; take = 0; op_vin = 1; op_in = 64'hE3; tick();
    op_vin = 0; take = 1; tick();
    check("sim_cred_1", {63'd0, avail}, 64'd1);
    tick();
    check("sim_cred_0", {63'd0, avail}, 64'd0);
    take = 0; op_rdy = 1; tick();
    op_rdy = 0;
    check("sim_cred_ret", {63'd0, avail}, 64'd1);
    check("sim_idle", {63'd0, cmd_ready}, 64'd1);
    check("sim_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lane_operand_buffer.md
# lane_operand_buffer

Per-lane operand buffer between the vector register file crossbar and one functional-unit operand consumer. It captures operands that the VRF delivers with no backpressure, one cycle after a granted read. It enforces that behaviour through a credit interface towards the operand requester, which may only issue a bank read while it holds a credit. It also counts the operands of the current instruction so the consumer receives a `last` marker on the final element.

## Interface
- `Depth`, 4: buffer entries; integer ≥ 2, not required to be a power of two.
- `DataWidth`, 64: operand width in bits; equals ELEN.
- `LenWidth`, 16: width of the per-instruction operand count.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous abort of the current instruction.
- `cmd_valid_i`  in  1  new instruction descriptor valid.
- `cmd_ready_o`  out  1  descriptor accepted when high together with `cmd_valid_i`.
- `cmd_len_i`  in  LenWidth  number of operands the instruction delivers.
- `credit_take_i`  in  1  requester issued one VRF read targeting this buffer (pulse per read).
- `credit_avail_o`  out  1  at least one credit free.
- `credit_err_o`  out  1  sticky; set when `credit_take_i` arrives with zero credits.
- `operand_i`  in  DataWidth  operand from the VRF crossbar.
- `operand_valid_i`  in  1  operand valid; no ready is returned.
- `operand_o`  out  DataWidth  operand to consumer.
- `operand_valid_o`  out  1  operand valid to consumer.
- `operand_ready_i`  in  1  consumer accepts; a pop happens when valid and ready are both high.
- `operand_last_o`  out  1  current output operand is the final one of the instruction.

## Operation
- **FIFO and credit counter.** Storage is a circular FIFO of `Depth` entries with wrapping read and write pointers and an occupancy counter of width $clog2(Depth+1).
- **Credit accounting.**
  - A credit counter of width $clog2(Depth+1) resets to `Depth`.
  - `credit_take_i` decrements it; each pop increments it.
  - A take and a pop in the same cycle leave it unchanged.
  - `credit_avail_o = (credits != 0)`.
  - A take when credits is 0 is ignored (the counter saturates at 0) and sets `credit_err_o`. Only reset clears `credit_err_o`.
- **Writes.** Every `operand_valid_i` writes the FIFO, except during a flush drop window.
  - A write when the FIFO is full is dropped and sets `credit_err_o`.
  - Simultaneous push and pop when full is legal.
- **Instruction FSM.**
  - IDLE: `cmd_ready_o` = 1.
    - A handshake with `cmd_len_i` > 0 loads `remaining` = `cmd_len_i` and moves to ACTIVE.
    - A handshake with `cmd_len_i` = 0 is accepted and the FSM stays in IDLE.
  - ACTIVE: `cmd_ready_o` = 0.
    - `operand_valid_o` = FIFO non-empty.
    - `operand_last_o` = `operand_valid_o && remaining == 1`.
    - Each pop decrements `remaining`. The pop with `remaining == 1` returns the FSM to IDLE.
  - In IDLE `operand_valid_o` = 0. Data may still accumulate in the FIFO in IDLE (the requester may prefetch once credits allow).
- **Flush.** `flush_i` has priority over everything else in its cycle. It:
  - empties the FIFO;
  - sets credits to `Depth`;
  - sets the FSM to IDLE with `remaining` = 0;
  - ignores a descriptor handshake in the same cycle (`cmd_ready_o` is forced low);
  - drops `operand_valid_i` in the flush cycle and in the following cycle, which covers a read issued before the flush under the 1-cycle VRF latency. Credit takes in that following cycle still count.
- **Reset mid-operation.** Reset returns every register to its reset value immediately. An in-flight operand arriving in the first cycle after reset release is written normally; the requester must not issue reads during reset.

## Timing
- **Output reset values:**
  - `operand_valid_o` = 0
  - `operand_last_o` = 0
  - `operand_o` = 0
  - `cmd_ready_o` = 1
  - `credit_avail_o` = 1
  - `credit_err_o` = 0
- **Read path.** A read granted at cycle t arrives at t+1. It is written at the end of t+1 and visible on `operand_o` at t+2 (without bypass).
- **Credit visibility.** A credit returned by a pop at cycle t is visible on `credit_avail_o` at t+1. A take at t is visible at t+1.
- **Handshake rule.** `operand_valid_o` is never withdrawn without a pop, except on flush. `operand_o` is stable while valid and not ready.
- **Descriptor timing.** A descriptor accepted at cycle t makes buffered data visible at t+1.

## Configuration
- `LANE_OPBUF_BYPASS_EN`
  - **Defined:** when the FIFO is empty, the FSM is ACTIVE and `operand_valid_i` is high, the operand is driven combinationally to `operand_o` with `operand_valid_o` = 1. If `operand_ready_i` is also high, it is consumed without being written, giving zero-cycle latency. If ready is low, it is written normally.
  - **Undefined:** all operands pass through the FIFO, with a minimum latency of one cycle from `operand_valid_i` to `operand_valid_o`.

## Test plan
- **Basic stream:** reset, descriptor len=3, 3 takes at t=0..2, VRF data 0xA,0xB,0xC at t=1..3, ready held high → outputs 0xA,0xB,0xC on t=2..4 (t=1..3 with bypass), `last` only with 0xC, FSM back to IDLE, `cmd_ready_o`=1.
- **Credit exhaustion:** Depth=4, 4 takes, ready low → `credit_avail_o`=0 after the fourth take. One pop → `credit_avail_o`=1 next cycle. A fifth take at zero credits → `credit_err_o`=1 and credits stay 0.
- **Backpressure and wrap:** len=10, ready toggled 1/0 every cycle, takes issued whenever `credit_avail_o`=1 → all 10 values appear in order, pointers wrap twice, no data loss, `credit_err_o`=0.
- **Flush with in-flight read:** take at t, flush at t, data at t+1 → data dropped, FIFO empty, credits=4, `operand_valid_o`=0. The next descriptor with len=1 delivers only new data.
- **Zero-length and simultaneous events:** descriptor len=0 → stays IDLE. Take and pop in the same cycle with credits=2 → credits stay 2.
